uart_pattern_cmd: RTL and testbench
===================================

// Module: uart_pattern_cmd
// PURPOSE
//  ASCII command parser between the UART receiver and the VGA test-pattern index register.
//  Consumes received bytes, decodes "P<hex><CR>" (set pattern) and "?<CR>" (query pattern).
//  Drives the 4-bit pattern select and sends a two-byte reply (status char + LF) through the UART transmitter handshake.
//  Replaces the raw "low nibble of any byte" pattern selection.
// PARAMETERS
//  TIMEOUT_CLKS  25_000_000  idle clocks inside a partial command before silent abort (1 s at 25 MHz)
//  PATTERN_W     4           width of pattern index
// PORTS
//  i_Clk         in   1   system clock (25 MHz)
//  i_Rst_L       in   1   synchronous reset, active low
//  i_RX_DV       in   1   one-cycle strobe, i_RX_Byte valid
//  i_RX_Byte     in   8   received byte
//  i_TX_Done     in   1   one-cycle strobe, transmitter finished current byte
//  o_TX_DV       out  1   one-cycle strobe, start transmitting o_TX_Byte
//  o_TX_Byte     out  8   byte to transmit, held stable until the matching i_TX_Done
//  o_Pattern     out  4   current pattern index
//  o_Pattern_DV  out  1   one-cycle strobe on every accepted set command, including same value
//  o_Overrun     out  1   one-cycle strobe, reply dropped because the reply path was busy
// BEHAVIOUR
//  Reset: one clock, synchronous, active low. i_Rst_L=0 at a clock edge gives o_Pattern=0, all strobes 0, o_TX_Byte=0x00.
//   Both FSMs go to idle and the timeout counter clears. Reset aborts any reply mid-sequence; a later i_TX_Done is ignored.
//  Parse FSM, advancing only on i_RX_DV:
//   P_IDLE: 'P'/'p' -> P_GOT_P; '?' -> P_GOT_Q; CR(0x0D)/LF(0x0A) -> stay, no reply; other -> P_DISCARD.
//   P_GOT_P: hex digit 0-9/A-F/a-f -> latch nibble, P_GOT_HEX; CR -> reply 'E', P_IDLE; other -> P_DISCARD.
//   P_GOT_HEX: CR -> o_Pattern<=nibble, o_Pattern_DV=1, reply 'K', P_IDLE; other -> P_DISCARD.
//   P_GOT_Q: CR -> reply hex char of o_Pattern ('0'-'9','A'-'F' uppercase), P_IDLE; other -> P_DISCARD.
//   P_DISCARD: ignore bytes until CR -> reply 'E', P_IDLE.
//  Latency: CR strobe at cycle N -> o_Pattern/o_Pattern_DV/reply latch at N+1 -> o_TX_DV at N+2.
//  Timeout: counter clears on every i_RX_DV and counts while the parse FSM is not in P_IDLE.
//   At count TIMEOUT_CLKS-1 the FSM returns to P_IDLE with no reply and no pattern change; counter saturates.
//  Reply FSM: T_IDLE -> T_SEND1 (o_TX_DV=1, byte=status, 1 cycle) -> T_WAIT1.
//   T_WAIT1 on i_TX_Done -> T_SEND2 (o_TX_DV=1, byte=0x0A) -> T_WAIT2.
//   T_WAIT2 on i_TX_Done -> T_IDLE. o_TX_Byte is held through each wait.
//  Single reply slot. A reply generated while the reply FSM is not T_IDLE is dropped and o_Overrun pulses.
//   The pattern update from the same command still applies.
//  i_RX_DV and i_TX_Done in the same cycle are both processed; the parser never stalls on TX.
//  i_TX_Done seen in T_IDLE/T_SEND* is ignored.
// STRUCTURE
//  Package uart_cmd_pkg: ASCII constants (CR, LF, 'P', 'p', '?', 'K', 'E').
//   Also holds the parse and reply state enums, and the reply char width.
//  Sub-module ascii_hex_codec (combinational): byte->{valid,nibble} decode and nibble->uppercase ASCII encode.
//  Top file: parse FSM, timeout counter, pattern register, reply FSM.
// TESTING
//  Bytes "P","7",CR -> o_Pattern=7, one o_Pattern_DV pulse at N+1; o_TX_DV with 0x4B ('K'), then 0x0A after the first i_TX_Done.
//  Bytes "p","c",CR then "?",CR -> o_Pattern=0xC; second reply 0x43 ('C'),0x0A.
//  Bytes "P","G","X",CR -> o_Pattern unchanged, no o_Pattern_DV; reply 0x45 ('E'),0x0A.
//  "P" then no byte for TIMEOUT_CLKS (bench uses TIMEOUT_CLKS=100), then "?",CR -> no reply to the partial command; query reply reports the prior pattern.
//  "P3",CR then "P5",CR completing before the first i_TX_Done -> o_Pattern=5, o_Overrun pulses once; only one 'K',LF sent.
//  i_Rst_L=0 for one cycle during T_WAIT1 -> o_Pattern=0, o_TX_DV stays 0, following i_TX_Done ignored; the next "?",CR replies '0'.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encodings and widths for the UART pattern command parser.
package uart_cmd_pkg;

    localparam int unsigned REPLY_CHAR_W = 8;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_P_UP  = 8'h50;
    localparam logic [7:0] ASCII_P_LO  = 8'h70;
    localparam logic [7:0] ASCII_QUERY = 8'h3F;
    localparam logic [7:0] ASCII_K     = 8'h4B;
    localparam logic [7:0] ASCII_E     = 8'h45;

    typedef enum logic [2:0] {
        P_IDLE,
        P_GOT_P,
        P_GOT_HEX,
        P_GOT_Q,
        P_DISCARD
    } parse_state_t;

    typedef enum logic [2:0] {
        T_IDLE,
        T_SEND1,
        T_WAIT1,
        T_SEND2,
        T_WAIT2
    } reply_state_t;

endpackage

// File: rtl/uart_pattern_cmd_if.sv
// UART receive/transmit handshake between the UART core (master) and the command parser (slave).
interface uart_pattern_cmd_if;
    import uart_cmd_pkg::*;

    logic                    i_RX_DV;
    logic [7:0]              i_RX_Byte;
    logic                    i_TX_Done;
    logic                    o_TX_DV;
    logic [REPLY_CHAR_W-1:0] o_TX_Byte;

    modport master (
        output i_RX_DV,
        output i_RX_Byte,
        output i_TX_Done,
        input  o_TX_DV,
        input  o_TX_Byte
    );

    modport slave (
        input  i_RX_DV,
        input  i_RX_Byte,
        input  i_TX_Done,
        output o_TX_DV,
        output o_TX_Byte
    );

endinterface

// File: rtl/ascii_hex_codec.sv
// Combinational ASCII hex helper: byte -> {valid, nibble} decode, nibble -> uppercase ASCII encode.
module ascii_hex_codec
    import uart_cmd_pkg::*;
(
    input  logic [7:0]              rx_byte,
    output logic                    dec_valid_c,
    output logic [3:0]              dec_nibble_c,
    input  logic [3:0]              enc_nibble,
    output logic [REPLY_CHAR_W-1:0] enc_char_c
);

    always_comb begin
        dec_valid_c  = 1'b0;
        dec_nibble_c = 4'h0;
        if (rx_byte >= 8'h30 && rx_byte <= 8'h39) begin
            dec_valid_c  = 1'b1;
            dec_nibble_c = 4'(rx_byte - 8'h30);
        end else if (rx_byte >= 8'h41 && rx_byte <= 8'h46) begin
            dec_valid_c  = 1'b1;
            dec_nibble_c = 4'(rx_byte - 8'h37);
        end else if (rx_byte >= 8'h61 && rx_byte <= 8'h66) begin
            dec_valid_c  = 1'b1;
            dec_nibble_c = 4'(rx_byte - 8'h57);
        end
    end

    always_comb begin
        enc_char_c = '0;
        if (enc_nibble < 4'd10) begin
            enc_char_c = REPLY_CHAR_W'(8'h30 + {4'h0, enc_nibble});
        end else begin
            enc_char_c = REPLY_CHAR_W'(8'h37 + {4'h0, enc_nibble});
        end
    end

endmodule

// File: rtl/uart_pattern_cmd.sv
// ASCII command parser ("P<hex><CR>" set, "?<CR>" query) driving the VGA pattern index,
// with a single-slot two-byte reply (status char + LF) through the UART transmitter handshake.
module uart_pattern_cmd
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CLKS = 25_000_000,
    parameter int unsigned PATTERN_W    = 4
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst_L,
    uart_pattern_cmd_if.slave    uart,
    output logic [PATTERN_W-1:0] o_Pattern,
    output logic                 o_Pattern_DV,
    output logic                 o_Overrun
);

    localparam int unsigned     CNT_W   = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CLKS - 1);

    parse_state_t            parse_state;
    reply_state_t            reply_state;
    logic [CNT_W-1:0]        idle_cnt;
    logic [3:0]              hex_nibble;
    logic                    reply_req;
    logic [REPLY_CHAR_W-1:0] reply_char;

    logic                    dec_valid_c;
    logic [3:0]              dec_nibble_c;
    logic [REPLY_CHAR_W-1:0] enc_char_c;

    ascii_hex_codec u_codec (
        .rx_byte      (uart.i_RX_Byte),
        .dec_valid_c  (dec_valid_c),
        .dec_nibble_c (dec_nibble_c),
        .enc_nibble   (4'(o_Pattern)),
        .enc_char_c   (enc_char_c)
    );

    // Parse FSM, timeout counter and pattern register; the reply is posted as a one-cycle request.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            parse_state  <= P_IDLE;
            idle_cnt     <= '0;
            hex_nibble   <= 4'h0;
            o_Pattern    <= '0;
            o_Pattern_DV <= 1'b0;
            reply_req    <= 1'b0;
            reply_char   <= '0;
        end else begin
            o_Pattern_DV <= 1'b0;
            reply_req    <= 1'b0;

            if (uart.i_RX_DV) begin
                idle_cnt <= '0;
            end else if (parse_state != P_IDLE && idle_cnt != CNT_MAX) begin
                idle_cnt <= idle_cnt + CNT_W'(1);
            end

            if (uart.i_RX_DV) begin
                case (parse_state)
                    P_IDLE: begin
                        if (uart.i_RX_Byte == ASCII_P_UP || uart.i_RX_Byte == ASCII_P_LO) begin
                            parse_state <= P_GOT_P;
                        end else if (uart.i_RX_Byte == ASCII_QUERY) begin
                            parse_state <= P_GOT_Q;
                        end else if (uart.i_RX_Byte != ASCII_CR && uart.i_RX_Byte != ASCII_LF) begin
                            parse_state <= P_DISCARD;
                        end
                    end
                    P_GOT_P: begin
                        if (dec_valid_c) begin
                            hex_nibble  <= dec_nibble_c;
                            parse_state <= P_GOT_HEX;
                        end else if (uart.i_RX_Byte == ASCII_CR) begin
                            reply_req   <= 1'b1;
                            reply_char  <= ASCII_E;
                            parse_state <= P_IDLE;
                        end else begin
                            parse_state <= P_DISCARD;
                        end
                    end
                    P_GOT_HEX: begin
                        if (uart.i_RX_Byte == ASCII_CR) begin
                            o_Pattern    <= PATTERN_W'(hex_nibble);
                            o_Pattern_DV <= 1'b1;
                            reply_req    <= 1'b1;
                            reply_char   <= ASCII_K;
                            parse_state  <= P_IDLE;
                        end else begin
                            parse_state <= P_DISCARD;
                        end
                    end
                    P_GOT_Q: begin
                        if (uart.i_RX_Byte == ASCII_CR) begin
                            reply_req   <= 1'b1;
                            reply_char  <= enc_char_c;
                            parse_state <= P_IDLE;
                        end else begin
                            parse_state <= P_DISCARD;
                        end
                    end
                    P_DISCARD: begin
                        if (uart.i_RX_Byte == ASCII_CR) begin
                            reply_req   <= 1'b1;
                            reply_char  <= ASCII_E;
                            parse_state <= P_IDLE;
                        end
                    end
                    default: parse_state <= P_IDLE;
                endcase
            end else if (parse_state != P_IDLE && idle_cnt == CNT_MAX) begin
                // Partial command went stale: abandon silently.
                parse_state <= P_IDLE;
            end
        end
    end

    // Reply FSM: status byte then LF, each held until the transmitter reports done.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            reply_state    <= T_IDLE;
            uart.o_TX_DV   <= 1'b0;
            uart.o_TX_Byte <= '0;
            o_Overrun      <= 1'b0;
        end else begin
            uart.o_TX_DV <= 1'b0;
            o_Overrun    <= 1'b0;

            case (reply_state)
                T_IDLE: begin
                    if (reply_req) begin
                        reply_state    <= T_SEND1;
                        uart.o_TX_DV   <= 1'b1;
                        uart.o_TX_Byte <= reply_char;
                    end
                end
                T_SEND1: reply_state <= T_WAIT1;
                T_WAIT1: begin
                    if (uart.i_TX_Done) begin
                        reply_state    <= T_SEND2;
                        uart.o_TX_DV   <= 1'b1;
                        uart.o_TX_Byte <= ASCII_LF;
                    end
                end
                T_SEND2: reply_state <= T_WAIT2;
                T_WAIT2: begin
                    if (uart.i_TX_Done) begin
                        reply_state <= T_IDLE;
                    end
                end
                default: reply_state <= T_IDLE;
            endcase

            if (reply_req && reply_state != T_IDLE) begin
                o_Overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_pattern_cmd.sv
// Randomized and directed bench for uart_pattern_cmd against a line-level command model.
module tb_uart_pattern_cmd;

    localparam int unsigned TIMEOUT = 100;

    typedef logic [7:0] byte_q_t[$];

    logic       i_Clk = 1'b0;
    logic       i_Rst_L = 1'b0;
    logic [3:0] o_Pattern;
    logic       o_Pattern_DV;
    logic       o_Overrun;

    uart_pattern_cmd_if bus ();

    uart_pattern_cmd #(
        .TIMEOUT_CLKS (TIMEOUT),
        .PATTERN_W    (4)
    ) dut (
        .i_Clk        (i_Clk),
        .i_Rst_L      (i_Rst_L),
        .uart         (bus),
        .o_Pattern    (o_Pattern),
        .o_Pattern_DV (o_Pattern_DV),
        .o_Overrun    (o_Overrun)
    );

    always #20 i_Clk = ~i_Clk;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] txq[$];
    int         pdv_cnt = 0;
    int         ovr_cnt = 0;
    bit         auto_done = 1'b1;
    int         done_delay = 1;
    int         manual_req = 0;
    int         manual_ack = 0;
    int         done_timer = -1;
    logic [3:0] model_pat = 4'h0;

    // Output monitor
    always @(negedge i_Clk) begin
        if (bus.o_TX_DV === 1'b1) txq.push_back(bus.o_TX_Byte);
        if (o_Pattern_DV === 1'b1) pdv_cnt++;
        if (o_Overrun === 1'b1) ovr_cnt++;
    end

    // Transmitter stand-in: done after a delay, or on explicit request
    always @(negedge i_Clk) begin
        bus.i_TX_Done = 1'b0;
        if (manual_req != manual_ack) begin
            bus.i_TX_Done = 1'b1;
            manual_ack = manual_req;
        end else if (done_timer == 0) begin
            bus.i_TX_Done = 1'b1;
            done_timer = -1;
        end else if (done_timer > 0) begin
            done_timer--;
        end
        if (auto_done && bus.o_TX_DV === 1'b1) done_timer = done_delay;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge i_Clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_RX_Byte = b;
        bus.i_RX_DV   = 1'b1;
        @(negedge i_Clk);
        bus.i_RX_DV   = 1'b0;
    endtask

    function automatic int hex_val(input logic [7:0] b);
        if (b >= 8'd48 && b <= 8'd57)  return int'(b) - 48;
        if (b >= 8'd65 && b <= 8'd70)  return int'(b) - 55;
        if (b >= 8'd97 && b <= 8'd102) return int'(b) - 87;
        return -1;
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] v);
        return (v < 4'd10) ? 8'(48 + int'(v)) : 8'(55 + int'(v));
    endfunction

    // Classify one CR-terminated line (terminator excluded) as a whole
    function automatic void model_line(input byte_q_t line, inout logic [3:0] pat,
                                       output bit has_reply, output logic [7:0] rch,
                                       output bit set);
        byte_q_t s = line;
        while (s.size() > 0 && s[0] == 8'h0A) void'(s.pop_front());
        has_reply = 1'b0;
        rch       = 8'h00;
        set       = 1'b0;
        if (s.size() == 0) return;
        has_reply = 1'b1;
        rch       = 8'h45;
        if (s.size() == 1 && s[0] == 8'h3F) begin
            rch = hex_char(pat);
        end else if (s.size() == 2 && (s[0] == 8'h50 || s[0] == 8'h70) && hex_val(s[1]) >= 0) begin
            pat = 4'(hex_val(s[1]));
            set = 1'b1;
            rch = 8'h4B;
        end
    endfunction

    task automatic run_cmd(input byte_q_t line, input int max_gap, input string tag);
        int         q0 = txq.size();
        int         p0 = pdv_cnt;
        int         o0 = ovr_cnt;
        bit         hr;
        bit         st;
        logic [7:0] rc;
        byte_q_t    full = line;
        model_line(line, model_pat, hr, rc, st);
        full.push_back(8'h0D);
        foreach (full[i]) begin
            tick($urandom_range(0, max_gap));
            send_byte(full[i]);
        end
        tick(40);
        check({tag, "_ntx"}, txq.size() - q0, hr ? 2 : 0);
        if (hr && txq.size() - q0 == 2) begin
            check({tag, "_status"}, txq[q0], rc);
            check({tag, "_lf"}, txq[q0 + 1], 8'h0A);
        end
        check({tag, "_pdv"}, pdv_cnt - p0, st ? 1 : 0);
        check({tag, "_ovr"}, ovr_cnt - o0, 0);
        check({tag, "_pat"}, o_Pattern, model_pat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int         q0;
        int         q1;
        int         o0;
        int         p0;
        int         v;
        logic [7:0] b;
        byte_q_t    q;

        bus.i_RX_DV   = 1'b0;
        bus.i_RX_Byte = 8'h00;
        i_Rst_L       = 1'b0;
        tick(3);
        check("rst_pat", o_Pattern, 0);
        check("rst_txdv", bus.o_TX_DV, 0);
        check("rst_txbyte", bus.o_TX_Byte, 0);
        check("rst_pdv", o_Pattern_DV, 0);
        check("rst_ovr", o_Overrun, 0);
        i_Rst_L = 1'b1;
        tick(2);

        // "P7" CR with cycle-exact latency
        q0 = txq.size();
        send_byte(8'h50);
        send_byte(8'h37);
        send_byte(8'h0D);
        check("lat_pdv", o_Pattern_DV, 1);
        check("lat_pat", o_Pattern, 7);
        check("lat_txdv_early", bus.o_TX_DV, 0);
        tick(1);
        check("lat_txdv", bus.o_TX_DV, 1);
        check("lat_txbyte", bus.o_TX_Byte, 8'h4B);
        check("lat_pdv_once", o_Pattern_DV, 0);
        tick(40);
        check("lat_ntx", txq.size() - q0, 2);
        check("lat_lf", txq[q0 + 1], 8'h0A);
        model_pat = 4'h7;

        q = '{8'h70, 8'h63};
        run_cmd(q, 2, "set_c");
        q = '{8'h3F};
        run_cmd(q, 2, "query_c");
        q = '{8'h50, 8'h47, 8'h58};
        run_cmd(q, 2, "bad_hex");

        // Partial command times out silently
        q0 = txq.size();
        send_byte(8'h50);
        tick(TIMEOUT + 10);
        check("tmo_silent", txq.size() - q0, 0);
        q = '{8'h3F};
        run_cmd(q, 1, "tmo_query");

        // Gaps well under the timeout keep the command alive
        q0 = txq.size();
        send_byte(8'h50);
        tick(60);
        send_byte(8'h35);
        tick(60);
        send_byte(8'h0D);
        tick(40);
        check("slow_pat", o_Pattern, 5);
        check("slow_ntx", txq.size() - q0, 2);
        check("slow_status", txq[q0], 8'h4B);
        model_pat = 4'h5;

        // Second command completes while the first reply is still pending
        auto_done = 1'b0;
        q0 = txq.size();
        o0 = ovr_cnt;
        p0 = pdv_cnt;
        send_byte(8'h50); send_byte(8'h33); send_byte(8'h0D);
        send_byte(8'h50); send_byte(8'h35); send_byte(8'h0D);
        tick(10);
        check("ovr_pulse", ovr_cnt - o0, 1);
        check("ovr_pat", o_Pattern, 5);
        check("ovr_pdv", pdv_cnt - p0, 2);
        check("ovr_first", txq.size() - q0, 1);
        manual_req++;
        tick(5);
        check("ovr_ntx2", txq.size() - q0, 2);
        check("ovr_lf", txq[q0 + 1], 8'h0A);
        manual_req++;
        tick(10);
        check("ovr_ntx_final", txq.size() - q0, 2);
        check("ovr_status", txq[q0], 8'h4B);
        auto_done = 1'b1;
        q = '{8'h3F};
        run_cmd(q, 1, "ovr_query");

        // Reset while waiting for the first TX done
        auto_done = 1'b0;
        q0 = txq.size();
        send_byte(8'h3F);
        send_byte(8'h0D);
        tick(4);
        check("rstmid_first", txq.size() - q0, 1);
        i_Rst_L = 1'b0;
        tick(1);
        i_Rst_L = 1'b1;
        check("rstmid_pat", o_Pattern, 0);
        check("rstmid_txdv", bus.o_TX_DV, 0);
        check("rstmid_txbyte", bus.o_TX_Byte, 0);
        q1 = txq.size();
        manual_req++;
        tick(10);
        check("rstmid_done_ignored", txq.size() - q1, 0);
        model_pat = 4'h0;
        auto_done = 1'b1;
        q = '{8'h3F};
        run_cmd(q, 1, "rstmid_query");

        // Random command lines
        for (int n = 0; n < 60; n++) begin
            done_delay = $urandom_range(0, 4);
            q = {};
            case ($urandom_range(0, 5))
                0: begin
                    v = $urandom_range(0, 15);
                    q.push_back(($urandom_range(0, 1) != 0) ? 8'h50 : 8'h70);
                    b = hex_char(4'(v));
                    if (v >= 10 && $urandom_range(0, 1) != 0) b = b + 8'h20;
                    q.push_back(b);
                end
                1: q.push_back(8'h3F);
                2: begin
                    for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
                        b = 8'($urandom_range(0, 255));
                        if (b == 8'h0D) b = 8'h0E;
                        q.push_back(b);
                    end
                end
                3: q.push_back(8'h50);
                4: if ($urandom_range(0, 1) != 0) q.push_back(8'h0A);
                default: begin
                    q.push_back(8'h0A);
                    q.push_back(8'h70);
                    q.push_back(hex_char(4'($urandom_range(0, 15))));
                end
            endcase
            run_cmd(q, 3, "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
